// File: rtl/envelope_gain_pkg.sv
// Shared types and default sizing for the envelope gain stage.
package envelope_pkg;

    // Envelope phase. The numeric values are visible on state_o.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_e;

    localparam int DATA_WIDTH_DEF   = 24;
    localparam int GAIN_WIDTH_DEF   = 16;
    localparam int ATTACK_STEP_DEF  = 64;
    localparam int RELEASE_STEP_DEF = 16;

endpackage

// File: rtl/envelope_gain_env_ramp.sv
// Gain/state register with saturating attack and release steps.
// It advances only on a stereo-frame boundary, so both channels of a
// frame always see the same gain.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | gain is 0, output silenced
// ATTACK  | gate held, gain rising toward full scale
// SUSTAIN | gate held, gain pinned at full scale
// RELEASE | gate released, gain falling toward 0
module env_ramp
    import envelope_pkg::*;
#(
    parameter int gain_width_p   = GAIN_WIDTH_DEF,
    parameter int attack_step_p  = ATTACK_STEP_DEF,
    parameter int release_step_p = RELEASE_STEP_DEF
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    boundary_i,
    input  logic                    gate_i,
    output logic [gain_width_p-1:0] gain_o,
    output env_state_e              state_o
);

    // One extra bit on the attack sum so saturation is visible before wrap.
    localparam logic [gain_width_p:0]   attack_w_lp  = (gain_width_p+1)'(attack_step_p);
    localparam logic [gain_width_p:0]   max_w_lp     = {1'b0, {gain_width_p{1'b1}}};
    localparam logic [gain_width_p-1:0] release_n_lp = gain_width_p'(release_step_p);

    logic [gain_width_p-1:0] gain_q, gain_d;
    env_state_e              state_q, state_d;
    logic [gain_width_p:0]   up_sum;
    logic [gain_width_p-1:0] down_diff;

    // Next gain and phase, evaluated from the gate seen at the boundary beat.
    always_comb begin
        up_sum    = {1'b0, gain_q} + attack_w_lp;
        down_diff = gain_q - release_n_lp;
        gain_d    = gain_q;
        state_d   = state_q;
        if (boundary_i) begin
            if (gate_i) begin
                if (up_sum >= max_w_lp) begin
                    gain_d  = {gain_width_p{1'b1}};
                    state_d = SUSTAIN;
                end else begin
                    gain_d  = up_sum[gain_width_p-1:0];
                    state_d = ATTACK;
                end
            end else begin
                // Compare before subtracting so the floor at 0 never wraps.
                if (gain_q <= release_n_lp) begin
                    gain_d  = '0;
                    state_d = IDLE;
                end else begin
                    gain_d  = down_diff;
                    state_d = RELEASE;
                end
            end
        end
    end

    // Gain and phase registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            gain_q  <= '0;
            state_q <= IDLE;
        end else begin
            gain_q  <= gain_d;
            state_q <= state_d;
        end
    end

    assign gain_o  = gain_q;
    assign state_o = state_q;

endmodule

// File: rtl/envelope_gain.sv
// Envelope stage between the tone generator and the I2S transmitter.
// A single output register carries the scaled sample; the multiplier
// sits in front of it so nothing on s_* reaches m_* combinationally.
module envelope_gain
    import envelope_pkg::*;
#(
    parameter int data_width_p   = DATA_WIDTH_DEF,
    parameter int gain_width_p   = GAIN_WIDTH_DEF,
    parameter int attack_step_p  = ATTACK_STEP_DEF,
    parameter int release_step_p = RELEASE_STEP_DEF
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    gate_i,
    input  logic [data_width_p-1:0] s_data_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic                    s_last_i,
    output logic [data_width_p-1:0] m_data_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic                    m_last_o,
    output logic [gain_width_p-1:0] gain_o,
    output logic [1:0]              state_o
);

    localparam int prod_width_lp = data_width_p + gain_width_p + 1;

    logic                           accept;
    logic                           frame_boundary;
    logic [gain_width_p-1:0]        gain_cur;
    env_state_e                     env_state;
    logic signed [prod_width_lp-1:0] data_ext;
    logic signed [prod_width_lp-1:0] gain_ext;
    logic signed [prod_width_lp-1:0] product;

    logic [data_width_p-1:0] m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;

    // Ready is held low during reset so nothing is accepted into a register being cleared.
    assign s_ready_o      = ~reset_i & (~m_valid_q | m_ready_i);
    assign accept         = s_valid_i & s_ready_o;
    assign frame_boundary = accept & s_last_i;

    // The boundary beat itself is scaled with the gain in effect before the update.
    env_ramp #(
        .gain_width_p   (gain_width_p),
        .attack_step_p  (attack_step_p),
        .release_step_p (release_step_p)
    ) u_env_ramp (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .boundary_i (frame_boundary),
        .gate_i     (gate_i),
        .gain_o     (gain_cur),
        .state_o    (env_state)
    );

    // Gain is treated as a positive signed value; the product cannot overflow.
    always_comb begin
        data_ext = prod_width_lp'(signed'(s_data_i));
        gain_ext = prod_width_lp'(signed'({1'b0, gain_cur}));
        product  = data_ext * gain_ext;
    end

    // Output register: load on accept, drain when the sink takes the beat.
    always_comb begin
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_valid_d = m_valid_q;
        if (accept) begin
            m_data_d  = data_width_p'(product >>> gain_width_p);
            m_last_d  = s_last_i;
            m_valid_d = 1'b1;
        end else if (m_ready_i) begin
            m_valid_d = 1'b0;
        end
    end

    // Output register flops; reset drops any beat in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_data_o  = m_data_q;
    assign m_last_o  = m_last_q;
    assign m_valid_o = m_valid_q;
    assign gain_o    = gain_cur;
    assign state_o   = env_state;

endmodule

// File: tb/tb_envelope_gain.sv
// Directed plus randomized bench for envelope_gain with a reference model.
module tb_envelope_gain;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        gate_i = 1'b0;
    logic [23:0] s_data_i = '0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic        s_last_i = 1'b0;
    logic [23:0] m_data_o;
    logic        m_valid_o;
    logic        m_ready_i = 1'b1;
    logic        m_last_o;
    logic [15:0] gain_o;
    logic [1:0]  state_o;

    always #5 clk_i = ~clk_i;

    envelope_gain #(
        .data_width_p   (24),
        .gain_width_p   (16),
        .attack_step_p  (64),
        .release_step_p (16)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .gate_i    (gate_i),
        .s_data_i  (s_data_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_last_i  (s_last_i),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_last_o  (m_last_o),
        .gain_o    (gain_o),
        .state_o   (state_o)
    );

    typedef struct packed {
        logic [23:0] d;
        logic        l;
    } beat_t;

    beat_t sb[$];      // beats accepted but not yet taken by the sink
    int    gm = 0;     // model gain
    int    sm = 0;     // model state: 0 idle, 1 attack, 2 sustain, 3 release
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // floor(x * g / 2^16) on the signed sample, kept to 24 bits
    function automatic logic [23:0] scale(input logic [23:0] x, input int g);
        longint p;
        p = longint'($signed(x)) * longint'(g);
        return 24'(p >>> 16);
    endfunction

    function automatic void env_update(input logic g);
        if (g) begin
            gm = (gm + 64 > 65535) ? 65535 : gm + 64;
            sm = (gm == 65535) ? 2 : 1;
        end else begin
            gm = (gm - 16 < 0) ? 0 : gm - 16;
            sm = (gm == 0) ? 0 : 3;
        end
    endfunction

    // One clock: drive at the falling edge, check before and after the rising edge.
    task automatic step(input logic v, input logic [23:0] d, input logic l,
                        input logic g, input logic r, input logic rst);
        logic  exp_rdy;
        logic  acc;
        logic  xfer;
        beat_t nb;
        s_valid_i = v;
        s_data_i  = d;
        s_last_i  = l;
        gate_i    = g;
        m_ready_i = r;
        reset_i   = rst;
        #1;
        exp_rdy = !rst && (sb.size() == 0 || r);
        chk("s_ready", {31'd0, s_ready_o}, {31'd0, exp_rdy});
        if (sb.size() != 0) begin
            chk("m_data", {8'd0, m_data_o}, {8'd0, sb[0].d});
            chk("m_last", {31'd0, m_last_o}, {31'd0, sb[0].l});
        end
        acc  = v && exp_rdy;
        xfer = !rst && sb.size() != 0 && r;
        @(posedge clk_i);
        if (rst) begin
            sb.delete();
            gm = 0;
            sm = 0;
        end else begin
            if (xfer) void'(sb.pop_front());
            if (acc) begin
                nb.d = scale(d, gm);
                nb.l = l;
                sb.push_back(nb);
                if (l) env_update(g);
            end
        end
        @(negedge clk_i);
        chk("m_valid", {31'd0, m_valid_o}, (sb.size() != 0) ? 32'd1 : 32'd0);
        chk("gain", {16'd0, gain_o}, 32'(gm));
        chk("state", {30'd0, state_o}, 32'(sm));
    endtask

    // One stereo frame (L then R) with occasional idle cycles in between.
    task automatic frame(input logic g);
        for (int b = 0; b < 2; b++) begin
            while ($urandom_range(0, 3) == 0) step(1'b0, 24'($urandom), 1'b0, g, 1'b1, 1'b0);
            step(1'b1, 24'($urandom), (b == 1), g, 1'b1, 1'b0);
        end
    endtask

    initial begin
        logic g;

        repeat (3) step(1'b1, 24'h123456, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_data", {8'd0, m_data_o}, 32'd0);
        chk("rst_last", {31'd0, m_last_o}, 32'd0);

        // Silent stream while idle; one beat out per cycle
        for (int i = 0; i < 20; i++) step(1'b1, 24'h400000, (i % 2 == 1), 1'b0, 1'b1, 1'b0);
        chk("idle_out", {8'd0, m_data_o}, 32'd0);
        chk("idle_state", {30'd0, state_o}, 32'd0);

        // Attack ramp to saturation
        for (int k = 1; k <= 1023; k++) frame(1'b1);
        chk("gain_k1023", {16'd0, gain_o}, 32'd65472);
        chk("state_k1023", {30'd0, state_o}, 32'd1);
        frame(1'b1);
        chk("gain_k1024", {16'd0, gain_o}, 32'd65535);
        chk("state_k1024", {30'd0, state_o}, 32'd2);

        // Full-scale scaling of both polarities
        step(1'b1, 24'h400000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("sus_pos", {8'd0, m_data_o}, 32'h3FFFC0);
        step(1'b1, 24'hC00000, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("sus_neg", {8'd0, m_data_o}, 32'hC00040);

        // Backpressure: output held, boundary-looking input must not move the envelope
        step(1'b1, 24'h0ABCDE, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 24'h765432, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("stall_gain", {16'd0, gain_o}, 32'd65535);
        end
        step(1'b1, 24'h765432, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Release with retrigger
        for (int n = 1; n <= 100; n++) frame(1'b0);
        chk("gain_n100", {16'd0, gain_o}, 32'd63935);
        chk("state_n100", {30'd0, state_o}, 32'd3);
        frame(1'b1);
        chk("gain_retrig", {16'd0, gain_o}, 32'd63999);
        chk("state_retrig", {30'd0, state_o}, 32'd1);
        for (int k = 0; k < 24; k++) frame(1'b1);
        chk("gain_resus", {16'd0, gain_o}, 32'd65535);

        // Full release to silence
        for (int n = 1; n <= 4095; n++) frame(1'b0);
        chk("gain_n4095", {16'd0, gain_o}, 32'd15);
        chk("state_n4095", {30'd0, state_o}, 32'd3);
        frame(1'b0);
        chk("gain_n4096", {16'd0, gain_o}, 32'd0);
        chk("state_n4096", {30'd0, state_o}, 32'd0);

        // Randomized traffic: gate toggles mid-frame, random valid/ready/last
        g = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) g = ~g;
            step(($urandom_range(0, 3) != 0), 24'($urandom), 1'($urandom), g,
                 ($urandom_range(0, 3) != 0), 1'b0);
        end

        // Reset in the middle of an attack with a beat in flight
        repeat (2) step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 50; k++) frame(1'b1);
        chk("gain_pre_rst", {16'd0, gain_o}, 32'd3200);
        chk("state_pre_rst", {30'd0, state_o}, 32'd1);
        step(1'b1, 24'h7FFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("valid_pre_rst", {31'd0, m_valid_o}, 32'd1);
        step(1'b1, 24'h000001, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_valid", {31'd0, m_valid_o}, 32'd0);
        chk("rst_gain", {16'd0, gain_o}, 32'd0);
        chk("rst_state", {30'd0, state_o}, 32'd0);
        chk("rst_mdata", {8'd0, m_data_o}, 32'd0);
        repeat (4) step(1'b1, 24'h200000, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
